// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM state encoding and owner constants for mem_arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } arb_state_t;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - combinational grant decision between dcache and icache
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic d_req,
  input  logic i_req,
  input  logic ptr,
  output logic grant_valid,
  output logic grant
);

  // ptr names the requester that wins a tie
  always_comb begin
    grant_valid = d_req | i_req;
    grant       = OWN_D;
    if (d_req && i_req) begin
      grant = ptr;
    end else if (i_req) begin
      grant = OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client (dcache/icache) arbiter in front of a single data memory
// Define ARB_ROUND_ROBIN_EN to alternate priority; default is fixed dcache priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              owner;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              aborted;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic              d_req;
  logic              i_req;
  logic              owner_req;
  logic              ptr;
  logic              grant_valid;
  logic              grant;

  assign d_req     = d_read | d_write;
  assign i_req     = i_read;
  assign owner_req = (owner == OWN_I) ? i_req : d_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // after every completed access the other requester gets the tie-break
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= OWN_D;
    end else if (state == DONE) begin
      rr_ptr <= ~owner;
    end
  end

  assign ptr = rr_ptr;
`else
  assign ptr = OWN_D;
`endif

  arb_pick u_arb_pick (
    .d_req       (d_req),
    .i_req       (i_req),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        mem_read  = ~lat_write;
        mem_write = lat_write;
        if (!mem_busywait) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // memory address/data come only from the request latched at arbitration
  assign mem_address   = lat_addr;
  assign mem_writedata = lat_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_D;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      aborted   <= 1'b0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner   <= grant;
            aborted <= 1'b0;
            if (grant == OWN_I) begin
              lat_write <= 1'b0;
              lat_addr  <= i_address;
              lat_wdata <= '0;
            end else begin
              lat_write <= d_write;
              lat_addr  <= d_address;
              lat_wdata <= d_writedata;
            end
          end
        end
        BUSY: begin
          // a requester that lets go at any point forfeits the response
          if (!owner_req) begin
            aborted <= 1'b1;
          end
          if (!mem_busywait && owner_req && !aborted && !lat_write) begin
            if (owner == OWN_I) begin
              i_rdata_q <= mem_readdata;
            end else begin
              d_rdata_q <= mem_readdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign d_readdata = d_rdata_q;
  assign i_readdata = i_rdata_q;

  assign d_busywait = reset & d_req &
                      ~((state == DONE) & (owner == OWN_D) & ~aborted);
  assign i_busywait = reset & i_req &
                      ~((state == DONE) & (owner == OWN_I) & ~aborted);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        d_read;
  logic        d_write;
  logic [5:0]  d_address;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        i_read;
  logic [5:0]  i_address;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory with a programmable stall of mem_lat cycles per access
  logic [31:0] mem_array [64];
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;
  int          mem_lat;
  logic [7:0]  mem_cnt;

  assign mem_busywait = (mem_read | mem_write) && (mem_cnt != 8'd0);
  assign mem_readdata = mem_array[mem_address];

  always @(posedge clock) begin
    if (!(mem_read | mem_write)) mem_cnt <= 8'(mem_lat);
    else if (mem_cnt != 8'd0)    mem_cnt <= mem_cnt - 8'd1;
    if (mem_write && !mem_busywait) mem_array[mem_address] <= mem_writedata;
    if (pl_en) mem_array[pl_addr] <= pl_data;
  end

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic [31:0] model_mem [64];
  logic [31:0] exp_d;
  logic [31:0] exp_i;
  int          n_checks;
  int          n_fail;
  int          cycles;
  int          cyc2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] v);
    pl_addr = a;
    pl_data = v;
    pl_en   = 1'b1;
    @(negedge clock);
    pl_en   = 1'b0;
    model_mem[a] = v;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_d = '0;
    exp_i = '0;
  endtask

  // op: 0 read, 1 write, 2 read+write (write wins); icache is read-only
  task automatic run_txn(input bit is_i, input int op, input logic [5:0] addr,
                         input logic [31:0] wd, input int lat);
    int  n;
    bit  wr;
    wr = !is_i && (op != 0);
    mem_lat = lat;
    if (is_i) begin
      i_read    = 1'b1;
      i_address = addr;
    end else begin
      d_read      = (op != 1);
      d_write     = (op != 0);
      d_address   = addr;
      d_writedata = wd;
    end
    #1;
    check("busy_rise", is_i ? i_busywait : d_busywait, 1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if ((is_i ? i_busywait : d_busywait) == 1'b1) begin
        check("mem_read", mem_read, !wr);
        check("mem_write", mem_write, wr);
        check("mem_addr", mem_address, addr);
        if (wr) check("mem_wdata", mem_writedata, wd);
        if (is_i) i_address = 6'($urandom);
        else begin
          d_address   = 6'($urandom);
          d_writedata = $urandom;
        end
      end
    end while ((is_i ? i_busywait : d_busywait) && n < 200);
    check("latency", n, lat + 2);
    check("idle_other_bw", is_i ? d_busywait : i_busywait, 0);
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    if (wr)        model_mem[addr] = wd;
    else if (is_i) exp_i = model_mem[addr];
    else           exp_d = model_mem[addr];
    @(negedge clock);
    check("d_rdata", d_readdata, exp_d);
    check("i_rdata", i_readdata, exp_i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
    i_read = 1'b0; i_address = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    mem_lat = 0;
    exp_d = '0;
    exp_i = '0;

    // reset state, with a request pending to show busywait is held low
    d_read = 1'b1;
    i_read = 1'b1;
    @(negedge clock);
    check("rst_d_bw", d_busywait, 0);
    check("rst_i_bw", i_busywait, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_d_rdata", d_readdata, 0);
    check("rst_i_rdata", i_readdata, 0);
    d_read = 1'b0;
    i_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    for (int a = 0; a < 64; a++) preload(6'(a), $urandom);

    // dcache read with a 5-cycle memory stall
    preload(6'h05, 32'hA1B2C3D4);
    run_txn(1'b0, 0, 6'h05, 32'h0, 5);
    check("d_read_05", d_readdata, 32'hA1B2C3D4);

    // dcache write, then read back
    run_txn(1'b0, 1, 6'h3F, 32'hDEADBEEF, 3);
    run_txn(1'b0, 0, 6'h3F, 32'h0, 1);
    check("d_readback_3F", d_readdata, 32'hDEADBEEF);

    // simultaneous requests: dcache first, icache right after
    mem_lat = 2;
    d_read = 1'b1; d_address = 6'h10;
    i_read = 1'b1; i_address = 6'h20;
    #1;
    check("both_d_bw", d_busywait, 1);
    check("both_i_bw", i_busywait, 1);
    cycles = 0;
    cyc2 = 0;
    do begin
      @(negedge clock);
      cycles++;
      if (cycles == 1) check("tie_addr_d", mem_address, 6'h10);
      if (!i_busywait) cyc2++;
    end while (d_busywait && cycles < 100);
    check("tie_d_latency", cycles, 4);
    check("tie_i_stalled", cyc2, 0);
    d_read = 1'b0;
    exp_d = model_mem[6'h10];
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
      if (cycles == 2) check("tie_addr_i", mem_address, 6'h20);
    end while (i_busywait && cycles < 100);
    check("tie_i_latency", cycles, 5);
    i_read = 1'b0;
    exp_i = model_mem[6'h20];
    @(negedge clock);
    check("tie_d_rdata", d_readdata, exp_d);
    check("tie_i_rdata", i_readdata, exp_i);

    // continuous contention for four grants
    pulse_reset();
    mem_lat = 1;
    d_read = 1'b1; d_address = 6'h11;
    i_read = 1'b1; i_address = 6'h22;
    for (int k = 0; k < 4; k++) begin
      int  n;
      bit  who;
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (d_busywait && i_busywait && n < 100);
      who = !i_busywait;
      check("grant_order", who, RR ? 1'(k % 2) : 1'b0);
      if (who) exp_i = model_mem[6'h22];
      else     exp_d = model_mem[6'h11];
      if (k == 3) begin
        d_read = 1'b0;
        i_read = 1'b0;
      end
      @(negedge clock);
    end
    check("rr_d_rdata", d_readdata, exp_d);
    check("rr_i_rdata", i_readdata, exp_i);

    // asynchronous reset in the middle of an access
    mem_lat = 8;
    d_read = 1'b1; d_address = 6'h17;
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_mem_read", mem_read, 1);
    reset = 1'b0;
    #1;
    check("midrst_mem_read", mem_read, 0);
    check("midrst_mem_write", mem_write, 0);
    check("midrst_mem_addr", mem_address, 0);
    check("midrst_mem_wdata", mem_writedata, 0);
    check("midrst_d_bw", d_busywait, 0);
    check("midrst_d_rdata", d_readdata, 0);
    check("midrst_i_rdata", i_readdata, 0);
    d_read = 1'b0;
    exp_d = '0;
    exp_i = '0;
    @(negedge clock);
    reset = 1'b1;
    run_txn(1'b0, 0, 6'h12, 32'h0, 2);

    // icache withdraws during BUSY, then re-requests
    run_txn(1'b1, 0, 6'h2B, 32'h0, 0);
    preload(6'h2A, ~exp_i);
    mem_lat = 3;
    i_read = 1'b1; i_address = 6'h2A;
    @(negedge clock);
    i_read = 1'b0;
    @(negedge clock);
    check("abort_bw_low", i_busywait, 0);
    i_read = 1'b1;
    cycles = 0;
    cyc2 = 0;
    while (mem_read && cycles < 50) begin
      @(negedge clock);
      cycles++;
      if (!i_busywait) cyc2++;
    end
    check("abort_completes", cycles, 3);
    check("abort_no_pulse", cyc2, 0);
    check("abort_i_rdata", i_readdata, exp_i);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (i_busywait && cycles < 50);
    check("rereq_latency", cycles, 6);
    i_read = 1'b0;
    exp_i = model_mem[6'h2A];
    @(negedge clock);
    check("rereq_i_rdata", i_readdata, exp_i);

    // randomized single-requester traffic
    for (int k = 0; k < 24; k++) begin
      bit ii;
      int op;
      ii = 1'($urandom_range(0, 1));
      op = ii ? 0 : int'($urandom_range(0, 2));
      run_txn(ii, op, 6'($urandom), $urandom, int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, memory block-address width.
REQ-002 Parameter DATA_W, default 32, memory block width.
REQ-003 clock  input  1  system clock, all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 d_read, d_write  input  1 each  dcache-side request strobes.
REQ-006 d_address  input  ADDR_W, d_writedata  input  DATA_W  dcache request address and write block.
REQ-007 d_readdata  output  DATA_W, d_busywait  output  1  dcache response block and stall.
REQ-008 i_read  input  1, i_address  input  ADDR_W  icache read-only request.
REQ-009 i_readdata  output  DATA_W, i_busywait  output  1  icache response block and stall.
REQ-010 mem_read, mem_write  output  1 each, mem_address  output  ADDR_W, mem_writedata  output  DATA_W  to data memory.
REQ-011 mem_readdata  input  DATA_W, mem_busywait  input  1  from data memory.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE plus a 1-bit owner register (0=dcache, 1=icache).
REQ-013 In IDLE, a rising edge with any pending request SHALL latch the winner's address, write data and operation, set owner, and enter BUSY.
REQ-014 Default priority SHALL be fixed: dcache beats icache on simultaneous requests.
REQ-015 In BUSY, mem_read/mem_write/mem_address/mem_writedata SHALL be driven from the latched request only, never from live requester inputs.
REQ-016 BUSY SHALL last at least one full cycle; a rising edge in BUSY with mem_busywait=0 SHALL capture mem_readdata into the owner's readdata register and enter DONE.
REQ-017 In DONE, mem_read and mem_write SHALL be 0, the owner's busywait SHALL be 0 for exactly that cycle, and the next edge SHALL return to IDLE.
REQ-018 x_busywait SHALL be 1 whenever x's request strobe is high and the FSM is not in DONE with owner=x; it SHALL be 0 with no request.
REQ-019 Busywait SHALL rise combinationally in the same cycle a request appears.
REQ-020 A losing requester SHALL remain stalled and be served on the next IDLE arbitration.
REQ-021 d_read and d_write both high SHALL be treated as a write.
REQ-022 A request withdrawn during BUSY SHALL still complete at memory; the response SHALL be discarded and no busywait pulse issued.
REQ-023 Readdata registers SHALL hold their last captured value until overwritten; a write transaction SHALL leave d_readdata unchanged.
REQ-024 Worst-case latency SHALL be 1 (arbitrate) + memory latency + 1 (DONE) cycles.

Reset
REQ-025 reset low SHALL force IDLE, owner=0, round-robin pointer=0, both readdata registers=0, mem_read=mem_write=0, mem_address=0, mem_writedata=0, asynchronously, including mid-transaction.
REQ-026 During reset, busywait outputs SHALL be 0.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: a pointer SHALL toggle after each DONE, giving priority to the requester not last served.
REQ-028 Macro undefined: fixed dcache priority per REQ-014, and no pointer flop is built.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and owner constants OWN_D=0, OWN_I=1.
REQ-030 The arbitration decision SHALL be one combinational sub-module, arb_pick, taking both requests and the pointer and returning the grant.

Verification
REQ-031 d_read=1, d_address=6'h05, memory returns 32'hA1B2C3D4 after 5 cycles -> mem_read high with mem_address=6'h05, d_busywait low for one cycle, d_readdata=32'hA1B2C3D4.
REQ-032 d_read and i_read asserted on the same edge -> dcache served first, i_busywait held high throughout, icache served immediately after.
REQ-033 With ARB_ROUND_ROBIN_EN, continuous d_read and i_read for 4 transactions -> grants alternate D,I,D,I; without the macro -> D,D,D,D.
REQ-034 d_write=1, d_address=6'h3F, d_writedata=32'hDEADBEEF -> mem_write=1, mem_writedata=32'hDEADBEEF, d_readdata unchanged.
REQ-035 reset pulsed low during BUSY -> mem_read drops immediately, FSM in IDLE, all outputs 0, next request served normally.
REQ-036 i_read withdrawn during BUSY -> memory access completes, i_readdata unchanged, no i_busywait pulse.
